// File: rtl/lsu_ctrl.sv
// Load/store sequencer: accepts one core request at a time, runs a req/ack
// transaction on the data memory and returns formatted load data or an error.
module lsu_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("lsu_ctrl: TIMEOUT must be at least 2");
    end
    if ((2 ** CNT_W) <= TIMEOUT) begin : g_bad_cnt_w
        $error("lsu_ctrl: CNT_W too narrow for TIMEOUT");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [1:0] CODE_MISALIGNED = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT    = 2'b10;
    localparam logic [1:0] CODE_ILLEGAL    = 2'b11;

    localparam logic [2:0] SZ_W  = 3'b001;
    localparam logic [2:0] SZ_B  = 3'b010;
    localparam logic [2:0] SZ_H  = 3'b011;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             lat_load;
    logic [2:0]       lat_size;
    logic [1:0]       lat_off;

    logic             size_ok;
    logic             misaligned;
    logic             is_half;
    logic             is_word;
    logic             timeout_hit;
    logic [3:0]       be_calc;
    logic [31:0]      wdata_calc;
    logic [31:0]      load_fmt;
    logic [7:0]       load_byte;
    logic [15:0]      load_half;

    // Request decode: legality is checked before alignment.
    always_comb begin
        size_ok    = 1'b0;
        is_half    = 1'b0;
        is_word    = 1'b0;
        misaligned = 1'b0;
        if (req_we) begin
            size_ok = (req_size == SZ_W) || (req_size == SZ_B) || (req_size == SZ_H);
            is_half = (req_size == SZ_H);
        end else begin
            size_ok = (req_size >= SZ_W) && (req_size <= SZ_HU);
            is_half = (req_size == SZ_H) || (req_size == SZ_HU);
        end
        is_word    = (req_size == SZ_W);
        misaligned = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
    end

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = req_wdata;
        if (req_we) begin
            case (req_size)
                SZ_B: begin
                    be_calc    = 4'b0001 << req_addr[1:0];
                    wdata_calc = {4{req_wdata[7:0]}};
                end
                SZ_H: begin
                    be_calc    = req_addr[1] ? 4'b1100 : 4'b0011;
                    wdata_calc = {2{req_wdata[15:0]}};
                end
                default: begin
                    be_calc    = 4'b1111;
                    wdata_calc = req_wdata;
                end
            endcase
        end
    end

    // Lane extraction uses the offset latched at acceptance, not the live address.
    always_comb begin
        load_byte = mem_rdata[7:0];
        case (lat_off)
            2'd0:    load_byte = mem_rdata[7:0];
            2'd1:    load_byte = mem_rdata[15:8];
            2'd2:    load_byte = mem_rdata[23:16];
            default: load_byte = mem_rdata[31:24];
        endcase
        load_half = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (lat_size)
            SZ_B:    load_fmt = {{24{load_byte[7]}}, load_byte};
            SZ_BU:   load_fmt = {24'h0, load_byte};
            SZ_H:    load_fmt = {{16{load_half[15]}}, load_half};
            SZ_HU:   load_fmt = {16'h0, load_half};
            default: load_fmt = mem_rdata;
        endcase
    end

    assign timeout_hit = (wait_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (!size_ok || misaligned) begin
                        next_state = ERR;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    next_state = RESP;
                end else if (timeout_hit) begin
                    next_state = ERR;
                end
            end
            RESP:    next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        stall       = ((state == IDLE) && req_valid) || (state == WAIT);
        rdata_valid = (state == RESP);
        err         = (state == ERR);
    end

    // Memory-side registers, wait counter, load result and error code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= '0;
            lat_load  <= 1'b0;
            lat_size  <= 3'b000;
            lat_off   <= 2'b00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
            rdata     <= 32'h0;
            err_code  <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (!size_ok) begin
                            err_code <= CODE_ILLEGAL;
                        end else if (misaligned) begin
                            err_code <= CODE_MISALIGNED;
                        end else begin
                            lat_load  <= !req_we;
                            lat_size  <= req_size;
                            lat_off   <= req_addr[1:0];
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= be_calc;
                            mem_wdata <= wdata_calc;
                        end
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        wait_cnt <= '0;
                        if (lat_load) begin
                            rdata <= load_fmt;
                        end
                    end else if (timeout_hit) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        wait_cnt <= '0;
                        err_code <= CODE_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized self-checking bench for lsu_ctrl with a transaction-level
// reference model of alignment, byte enables, lane replication and load extension.
module tb_lsu_ctrl;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        err;
    logic [1:0]  err_code;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rdata;

    lsu_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .err         (err),
        .err_code    (err_code),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Access width in bytes; 0 means the size code is not legal for this direction.
    function automatic int accessBytes(input logic we, input logic [2:0] size);
        int sz;
        sz = int'(size);
        if (sz == 1) return 4;
        if (sz == 2) return 1;
        if (sz == 3) return 2;
        if (!we && sz == 4) return 1;
        if (!we && sz == 5) return 2;
        return 0;
    endfunction

    function automatic logic [1:0] expErrCode(input logic we, input logic [2:0] size, input logic [31:0] addr);
        int bytes;
        bytes = accessBytes(we, size);
        if (bytes == 0) return 2'b11;
        if ((addr % bytes) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [3:0] expBe(input logic we, input logic [2:0] size, input logic [31:0] addr);
        int bytes;
        int mask;
        bytes = accessBytes(we, size);
        if (!we || bytes == 4) return 4'hF;
        mask = ((1 << bytes) - 1) << (addr % 4);
        return mask[3:0];
    endfunction

    function automatic logic [31:0] expWdata(input logic [2:0] size, input logic [31:0] wdata);
        int bytes;
        bytes = accessBytes(1'b1, size);
        if (bytes == 1) return (wdata & 32'hFF) * 32'h0101_0101;
        if (bytes == 2) return (wdata & 32'hFFFF) * 32'h0001_0001;
        return wdata;
    endfunction

    function automatic logic [31:0] expLoad(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] word);
        int          bytes;
        logic [31:0] mask;
        logic [31:0] val;
        logic        is_signed;
        bytes = accessBytes(1'b0, size);
        if (bytes == 4) return word;
        is_signed = (size == 3'b010) || (size == 3'b011);
        mask = (32'h1 << (8 * bytes)) - 32'h1;
        val  = (word >> (8 * (addr % 4))) & mask;
        if (is_signed && ((val & ((mask >> 1) + 32'h1)) != 0)) val = val | ~mask;
        return val;
    endfunction

    // In RESP/ERR the core may drive anything; it must be ignored.
    task automatic junkIdle();
        req_valid = 1'($urandom_range(0, 1));
        req_we    = 1'($urandom_range(0, 1));
        req_size  = 3'($urandom);
        req_addr  = $urandom;
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        @(posedge clk);
        @(negedge clk);
        checkOutput("idle_rdata_valid", 32'(rdata_valid), 32'd0);
        checkOutput("idle_err", 32'(err), 32'd0);
        checkOutput("idle_mem_req", 32'(mem_req), 32'd0);
        checkOutput("idle_stall", 32'(stall), 32'(req_valid));
        checkOutput("idle_rdata", rdata, exp_rdata);
    endtask

    // One full transaction from the IDLE negedge; ack_at=0 means never acknowledge.
    task automatic applyStimulus(input logic we, input logic [2:0] size, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rword, input int ack_at);
        logic [1:0] code;
        bit         done;
        code      = expErrCode(we, size, addr);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        #1;
        checkOutput("stall_c0", 32'(stall), 32'd1);
        checkOutput("mem_req_c0", 32'(mem_req), 32'd0);
        @(posedge clk);
        @(negedge clk);
        if (code != 2'b00) begin
            checkOutput("err_pulse", 32'(err), 32'd1);
            checkOutput("err_code", 32'(err_code), 32'(code));
            checkOutput("err_stall", 32'(stall), 32'd0);
            checkOutput("err_mem_req", 32'(mem_req), 32'd0);
            checkOutput("err_rdata_valid", 32'(rdata_valid), 32'd0);
            checkOutput("err_rdata", rdata, exp_rdata);
            junkIdle();
            return;
        end
        checkOutput("mem_we", 32'(mem_we), 32'(we));
        checkOutput("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        checkOutput("mem_be", 32'(mem_be), 32'(expBe(we, size, addr)));
        if (we) checkOutput("mem_wdata", mem_wdata, expWdata(size, wdata));
        done = 0;
        for (int cyc = 1; cyc <= TIMEOUT; cyc++) begin
            checkOutput("wait_mem_req", 32'(mem_req), 32'd1);
            checkOutput("wait_stall", 32'(stall), 32'd1);
            checkOutput("wait_rdata_valid", 32'(rdata_valid), 32'd0);
            checkOutput("wait_err", 32'(err), 32'd0);
            checkOutput("wait_mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
            if (cyc == ack_at) begin
                mem_ack   = 1'b1;
                mem_rdata = rword;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
            @(posedge clk);
            @(negedge clk);
            if (cyc == ack_at) begin
                done = 1;
                break;
            end
        end
        mem_ack = 1'b0;
        if (done) begin
            if (!we) exp_rdata = expLoad(size, addr, rword);
            checkOutput("resp_rdata_valid", 32'(rdata_valid), 32'd1);
            checkOutput("resp_err", 32'(err), 32'd0);
            checkOutput("resp_stall", 32'(stall), 32'd0);
            checkOutput("resp_mem_req", 32'(mem_req), 32'd0);
            checkOutput("resp_mem_we", 32'(mem_we), 32'd0);
            checkOutput("resp_rdata", rdata, exp_rdata);
        end else begin
            checkOutput("tmo_err", 32'(err), 32'd1);
            checkOutput("tmo_err_code", 32'(err_code), 32'd2);
            checkOutput("tmo_mem_req", 32'(mem_req), 32'd0);
            checkOutput("tmo_rdata_valid", 32'(rdata_valid), 32'd0);
            checkOutput("tmo_rdata", rdata, exp_rdata);
        end
        junkIdle();
    endtask

    task automatic resetMidWait();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 3'b001;
        req_addr  = 32'h0000_6000;
        mem_ack   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rstw_mem_req_before", 32'(mem_req), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 1'b0;
        #1;
        exp_rdata = 32'h0;
        checkOutput("rstw_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rstw_stall", 32'(stall), 32'd0);
        checkOutput("rstw_rdata", rdata, 32'h0);
        mem_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("rstw_no_valid", 32'(rdata_valid), 32'd0);
            checkOutput("rstw_no_err", 32'(err), 32'd0);
            checkOutput("rstw_no_req", 32'(mem_req), 32'd0);
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        int          ack_at;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = 3'b000;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        exp_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_mem_be", 32'(mem_be), 32'd0);
        checkOutput("rst_rdata", rdata, 32'h0);
        checkOutput("rst_rdata_valid", 32'(rdata_valid), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_err_code", 32'(err_code), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(1'b0, 3'b010, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1);
        applyStimulus(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_0001, 2);
        applyStimulus(1'b0, 3'b011, 32'h0000_2000, 32'h0, 32'hBEEF_0001, 3);
        applyStimulus(1'b1, 3'b010, 32'h0000_3001, 32'h0000_00AB, 32'h0, 1);
        applyStimulus(1'b1, 3'b011, 32'h0000_3002, 32'h0000_1234, 32'h0, 2);
        applyStimulus(1'b1, 3'b001, 32'h0000_4002, 32'h1111_2222, 32'h0, 1);
        applyStimulus(1'b0, 3'b110, 32'h0000_4000, 32'h0, 32'h0, 1);
        applyStimulus(1'b0, 3'b001, 32'h0000_5000, 32'h0, 32'h0, 0);
        applyStimulus(1'b0, 3'b001, 32'h0000_5004, 32'h0, 32'hCAFE_F00D, TIMEOUT);
        resetMidWait();
        applyStimulus(1'b0, 3'b100, 32'h0000_7001, 32'h0, 32'h0000_9A00, 1);

        for (int n = 0; n < 150; n++) begin
            we   = 1'($urandom_range(0, 1));
            size = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(1, we ? 3 : 5)) : 3'($urandom);
            addr = $urandom;
            if ($urandom_range(0, 1) != 0) addr[1:0] = 2'b00;
            if ($urandom_range(0, 9) == 0) ack_at = 0;
            else if ($urandom_range(0, 9) == 0) ack_at = TIMEOUT;
            else ack_at = $urandom_range(1, 5);
            applyStimulus(we, size, addr, $urandom, $urandom, ack_at);
        end

        req_valid = 1'b0;
        mem_ack   = 1'b0;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Multi-cycle load/store sequencer between the core's execute stage and a handshaked data memory.
- Accepts one request at a time and stalls the core while the request is in flight.
- Memory side uses a req/ack handshake. Generates word-aligned addresses, byte enables and lane-replicated store data.
- Returns sign- or zero-extended load data using the core's memto_reg size encoding, and flags misaligned accesses, illegal sizes and memory timeouts.

Parameters:
- TIMEOUT, 16: maximum cycles mem_req may stay high without mem_ack before a timeout error; must be ≥2.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  core request; held stable by the core while stall=1.
- req_we  in  1  1=store, 0=load.
- req_size  in  3  load: 001 lw, 010 lb, 011 lh, 100 lbu, 101 lhu; store: 001 sw, 010 sb, 011 sh.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- stall  out  1  core must hold its state.
- rdata  out  32  formatted load result.
- rdata_valid  out  1  one-cycle completion pulse (loads and stores).
- err  out  1  one-cycle error pulse.
- err_code  out  2  01 misaligned, 10 timeout, 11 illegal size; valid only when err=1.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_addr  out  32  {req_addr[31:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  memory completion; mem_rdata valid in the same cycle.
- mem_rdata  in  32  read word.

Behaviour:
- Reset (async, rst=1): state=IDLE, wait counter=0, all outputs 0 including rdata. Reset during WAIT drops mem_req immediately; no completion or error is produced.
- States: IDLE, WAIT, RESP, ERR.
- stall = (state==IDLE && req_valid) || state==WAIT. stall is 0 in RESP and ERR.
- IDLE with req_valid, checked in priority order:
  - Illegal size (load 000/110/111, or store other than 001/010/011) -> ERR with err_code 11.
  - Misaligned (half-word with addr[0]=1, or word with addr[1:0]≠0) -> ERR with err_code 01.
  - Otherwise latch we/size/addr/wdata and go to WAIT. mem_req, mem_we, mem_addr, mem_be and mem_wdata become registered outputs from the next cycle.
- mem_be and mem_wdata:
  - Loads: be=1111.
  - sw: be=1111, wdata as given.
  - sb: be=0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - sh: be=0011 when addr[1]=0, 1100 when addr[1]=1; wdata={2{wdata[15:0]}}.
- WAIT:
  - mem_* outputs are held constant until mem_ack=1.
  - On mem_ack: mem_req and mem_we drop next cycle; loads register the formatted mem_rdata into rdata; go to RESP.
  - Without ack: counter increments.
  - If counter==TIMEOUT-1 and no ack -> ERR with err_code 10; mem_req drops.
  - Ack in that same cycle wins over timeout.
  - Counter clears on leaving WAIT.
- Load formatting by latched addr[1:0]:
  - lb/lbu select byte lane addr[1:0], sign- or zero-extended.
  - lh/lhu select bits [31:16] when addr[1]=1, otherwise [15:0], sign- or zero-extended.
  - lw passes mem_rdata through unchanged.
- RESP: rdata_valid=1 for one cycle, then IDLE. For stores, rdata keeps its previous value.
- ERR: err=1 for one cycle with err_code, rdata unchanged, no memory transaction, then IDLE.
- Latency: acceptance at cycle 0, mem_req high at cycle 1. Ack at cycle k≥1 gives rdata_valid at k+1. Minimum 2 cycles.
- Back-to-back: a new request can be sampled in the IDLE cycle after RESP/ERR.
- mem_ack outside WAIT is ignored.
- req_valid changing while stall=0 in RESP/ERR has no effect until IDLE.

Test Plan:
- lb, addr 0x1003, mem_rdata 0x80FF_1234, ack on first mem_req cycle -> mem_addr 0x1000, be 1111, rdata 0xFFFF_FF80, rdata_valid at cycle 2, stall high for cycles 0-1.
- lhu, addr 0x2002, rdata 0xBEEF_0001 -> rdata 0x0000_BEEF; lh, addr 0x2000 -> 0x0000_0001.
- sb, addr 0x3001, wdata 0x0000_00AB -> mem_we=1, be 0010, mem_wdata 0xABAB_ABAB; sh, addr 0x3002 -> be 1100.
- sw, addr 0x4002 -> err=1, err_code 01, mem_req never asserted; load with size 110 -> err_code 11.
- No ack with TIMEOUT=16 -> mem_req high exactly 16 cycles, then err with err_code 10. Repeat with ack on cycle 16 -> normal completion and no error.
- rst asserted mid-WAIT -> mem_req and stall 0 immediately, no rdata_valid; the next request completes normally.
